// File: rtl/vga_framebuffer_scanout_pkg.sv
// ----------------------------------------------------------------------------
// vga_framebuffer_scanout_pkg
//   Shared definitions for the VGA framebuffer scanout block:
//   - COLOR_* 3-bit {R,G,B} codes
//   - default 640x480@60 timing constants (pixel ticks / lines)
//   - counter and framebuffer address widths
//   - the per-pixel flag bundle carried through pipeline stage S1
// ----------------------------------------------------------------------------
package vga_framebuffer_scanout_pkg;

    // Colour codes, {R,G,B}
    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_BLUE   = 3'b001;
    localparam logic [2:0] COLOR_GREEN  = 3'b010;
    localparam logic [2:0] COLOR_RED    = 3'b100;
    localparam logic [2:0] COLOR_YELLOW = 3'b110;
    localparam logic [2:0] COLOR_WHITE  = 3'b111;

    // Default timing: horizontal in pixel ticks, vertical in lines
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Framebuffer window placement on screen
    localparam int WIN_X0_DEF = 192;
    localparam int WIN_Y0_DEF = 112;
    localparam int WIN_SIZE   = 256;

    // Widths
    localparam int CNT_W      = 10;   // h/v counters (800 and 525 both fit)
    localparam int FB_COORD_W = 8;    // framebuffer column / row
    localparam int FB_ADDR_W  = 2 * FB_COORD_W;

    // Flags captured alongside the framebuffer address in stage S1
    typedef struct packed {
        logic in_win;
        logic vis;
        logic hs;
        logic vs;
        logic border;
    } scan_flags_t;

    // Idle value: syncs inactive (high), nothing visible
    localparam scan_flags_t SCAN_FLAGS_IDLE = '{
        in_win: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, border: 1'b0
    };

    // RAM address layout: column in the upper byte, row in the lower byte
    function automatic logic [FB_ADDR_W-1:0] fb_addr_pack(
        input logic [FB_COORD_W-1:0] col,
        input logic [FB_COORD_W-1:0] row
    );
        return {col, row};
    endfunction

endpackage

// File: rtl/vga_framebuffer_scanout_timing.sv
// ----------------------------------------------------------------------------
// vga_framebuffer_scanout_timing
//   Pixel-tick generator and horizontal/vertical raster counters.
//   A 1-bit phase toggles every clock; the pixel tick is phase==1, giving a
//   tick every second clock. Counters advance only on a tick.
// Ports
//   clk        in   system clock, rising edge
//   srst       in   synchronous active-high reset
//   tick       out  pixel tick (one clock wide, every 2nd clock)
//   h_cnt      out  horizontal position, 0..H_TOTAL-1
//   v_cnt      out  vertical position, 0..V_TOTAL-1
//   hs_raw     out  horizontal sync for current position, active-low
//   vs_raw     out  vertical sync for current position, active-low
//   vis_raw    out  current position is inside the visible area
//   frame_wrap out  tick on the last position of the frame (wraps to 0,0)
// ----------------------------------------------------------------------------
module vga_framebuffer_scanout_timing
    import vga_framebuffer_scanout_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             srst,
    output logic             tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             vis_raw,
    output logic             frame_wrap
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             phase_reg;
    logic [CNT_W-1:0] h_reg;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_reg;
    logic [CNT_W-1:0] v_next;
    logic             h_last;
    logic             v_last;

    always_comb begin
        h_last = (h_reg == H_LAST);
        v_last = (v_reg == V_LAST);
        h_next = h_last ? '0 : h_reg + CNT_W'(1);
        v_next = v_reg;
        if (h_last) begin
            v_next = v_last ? '0 : v_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            phase_reg <= 1'b0;
            h_reg     <= '0;
            v_reg     <= '0;
        end else begin
            phase_reg <= ~phase_reg;
            if (phase_reg) begin
                h_reg <= h_next;
                v_reg <= v_next;
            end
        end
    end

    assign tick       = phase_reg;
    assign h_cnt      = h_reg;
    assign v_cnt      = v_reg;
    assign hs_raw     = ~((h_reg >= HS_START) && (h_reg < HS_END));
    assign vs_raw     = ~((v_reg >= VS_START) && (v_reg < VS_END));
    assign vis_raw    = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);
    assign frame_wrap = phase_reg && h_last && v_last;

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// ----------------------------------------------------------------------------
// vga_framebuffer_scanout
//   Read side of the 256x256x3 video RAM. Scans a 640x480@60 raster (pixel
//   tick every 2nd clock of the 50 MHz clock), reads the framebuffer while the
//   raster is inside the window placed at (WIN_X0, WIN_Y0) and drives the VGA
//   pins; everything outside the window is black.
//   Optional feature, macro VGA_BORDER_EN: a 1-pixel white frame is drawn just
//   outside the window where it falls on visible pixels. Without the macro
//   those pixels are black.
// Ports
//   Clock          in   50 MHz system clock, rising edge
//   Reset          in   synchronous active-high reset
//   iFbData        in   RAM read data {R,G,B}, one clock after the read
//   oFbAddress     out  RAM address {col[7:0], row[7:0]}, held when idle
//   oFbReadEnable  out  one-clock read strobe for oFbAddress
//   oVGA_R/G/B     out  colour pins
//   oVGA_HS        out  horizontal sync, active-low
//   oVGA_VS        out  vertical sync, active-low
//   oFrameStart    out  one-clock pulse on the tick that wraps to (0,0)
// Pipeline (both stages advance on the pixel tick):
//   S1: window compare, address, read strobe, raw flags captured
//   S2: colour select from iFbData, syncs re-aligned with colour
//   Pins therefore show a position 2 ticks (4 clocks) after the counters.
// WIN_X0 and WIN_Y0 must be at least 1 and WIN_Xx0+256 must fit in 10 bits.
// ----------------------------------------------------------------------------
module vga_framebuffer_scanout
    import vga_framebuffer_scanout_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int WIN_X0    = WIN_X0_DEF,
    parameter int WIN_Y0    = WIN_Y0_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [2:0]           iFbData,
    output logic [FB_ADDR_W-1:0] oFbAddress,
    output logic                 oFbReadEnable,
    output logic                 oVGA_R,
    output logic                 oVGA_G,
    output logic                 oVGA_B,
    output logic                 oVGA_HS,
    output logic                 oVGA_VS,
    output logic                 oFrameStart
);

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic             vis_raw;
    logic             frame_wrap;

    vga_framebuffer_scanout_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk        (Clock),
        .srst       (Reset),
        .tick       (tick),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .vis_raw    (vis_raw),
        .frame_wrap (frame_wrap)
    );

    // Axis 0 is horizontal (column), axis 1 is vertical (row)
    logic [1:0][CNT_W-1:0]      pos_cnt;
    logic [1:0][FB_COORD_W-1:0] fb_coord;
    logic [1:0]                 axis_in;
    logic                       border_now;

    assign pos_cnt[0] = h_cnt;
    assign pos_cnt[1] = v_cnt;

    // Window test is a plain range compare on the 10-bit counter, so a
    // position left of / above the window never aliases into it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int               ORG     = (gi == 0) ? WIN_X0 : WIN_Y0;
            localparam logic [CNT_W-1:0] ORG_LO  = CNT_W'(ORG);
            localparam logic [CNT_W-1:0] ORG_END = CNT_W'(ORG + WIN_SIZE);
            assign fb_coord[gi] = FB_COORD_W'(pos_cnt[gi] - ORG_LO);
            assign axis_in[gi]  = (pos_cnt[gi] >= ORG_LO) && (pos_cnt[gi] < ORG_END);
        end
    endgenerate

`ifdef VGA_BORDER_EN
    // Ring one pixel outside the window: on an edge line of one axis while
    // within the extended span [ORG-1, ORG+256] of the other axis.
    logic [1:0] axis_edge;
    logic [1:0] axis_span;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_border
            localparam int               ORG     = (gi == 0) ? WIN_X0 : WIN_Y0;
            localparam logic [CNT_W-1:0] RING_LO = CNT_W'(ORG - 1);
            localparam logic [CNT_W-1:0] RING_HI = CNT_W'(ORG + WIN_SIZE);
            assign axis_edge[gi] = (pos_cnt[gi] == RING_LO) || (pos_cnt[gi] == RING_HI);
            assign axis_span[gi] = (pos_cnt[gi] >= RING_LO) && (pos_cnt[gi] <= RING_HI);
        end
    endgenerate
    assign border_now = (axis_edge[0] && axis_span[1]) || (axis_edge[1] && axis_span[0]);
`else
    assign border_now = 1'b0;
`endif

    scan_flags_t          s1_next;
    scan_flags_t          s1_reg;
    logic [FB_ADDR_W-1:0] fb_addr_reg;
    logic                 rd_en_reg;
    logic [2:0]           rgb_reg;
    logic                 hs_reg;
    logic                 vs_reg;

    always_comb begin
        s1_next        = SCAN_FLAGS_IDLE;
        s1_next.in_win = &axis_in;
        s1_next.vis    = vis_raw;
        s1_next.hs     = hs_raw;
        s1_next.vs     = vs_raw;
        s1_next.border = border_now;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_reg      <= SCAN_FLAGS_IDLE;
            fb_addr_reg <= '0;
            rd_en_reg   <= 1'b0;
            rgb_reg     <= COLOR_BLACK;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
        end else begin
            // Read strobe lasts exactly the clock after the S1 tick
            rd_en_reg <= tick && s1_next.in_win;
            if (tick) begin
                // S1
                s1_reg <= s1_next;
                if (s1_next.in_win) begin
                    fb_addr_reg <= fb_addr_pack(fb_coord[0], fb_coord[1]);
                end
                // S2: iFbData now holds the word read for s1_reg's position
                if (s1_reg.vis && s1_reg.in_win) begin
                    rgb_reg <= iFbData;
                end else if (s1_reg.vis && s1_reg.border) begin
                    rgb_reg <= COLOR_WHITE;
                end else begin
                    rgb_reg <= COLOR_BLACK;
                end
                hs_reg <= s1_reg.hs;
                vs_reg <= s1_reg.vs;
            end
        end
    end

    assign oFbAddress    = fb_addr_reg;
    assign oFbReadEnable = rd_en_reg;
    assign oVGA_R        = rgb_reg[2];
    assign oVGA_G        = rgb_reg[1];
    assign oVGA_B        = rgb_reg[0];
    assign oVGA_HS       = hs_reg;
    assign oVGA_VS       = vs_reg;
    // Held low while Reset is asserted so the pulse can't fire mid-reset
    assign oFrameStart   = frame_wrap && !Reset;

endmodule
